// File: rtl/execute_stage.sv
// Execute stage of the pipelined OTTER core: ALU, branch evaluation, redirect
// generation, wrong-path squash and the EX/MEM pipeline register.
module execute_stage #(
  parameter int XLEN         = 32,
  parameter int SQUASH_SLOTS = 2
) (
  input  logic            REG_CLOCK,
  input  logic            REG_RESET,
  input  logic            EX_STALL,
  input  logic            DEC_VALID,
  input  logic [XLEN-1:0] DEC_PC,
  input  logic [XLEN-1:0] DEC_PC_OUT,
  input  logic [XLEN-1:0] DEC_ALU_A,
  input  logic [XLEN-1:0] DEC_ALU_B,
  input  logic [XLEN-1:0] DEC_RS1,
  input  logic [XLEN-1:0] DEC_RS2,
  input  logic [XLEN-1:0] DEC_J_TYPE,
  input  logic [XLEN-1:0] DEC_B_TYPE,
  input  logic [XLEN-1:0] DEC_I_TYPE,
  input  logic [31:0]     DEC_MEM_IR,
  input  logic [3:0]      DEC_ALU_FUN,
  input  logic            DEC_REGWRITE,
  input  logic            DEC_MEMWRITE,
  input  logic            DEC_MEMREAD_2,
  input  logic [1:0]      DEC_RF_WR_SEL,
  output logic            EX_PC_SEL,
  output logic [XLEN-1:0] EX_TARGET,
  output logic            EX_VALID,
  output logic [XLEN-1:0] EX_ALU_RESULT,
  output logic [XLEN-1:0] EX_RS2_DATA,
  output logic [31:0]     EX_MEM_IR,
  output logic [XLEN-1:0] EX_PC_4,
  output logic            EX_REGWRITE,
  output logic            EX_MEMWRITE,
  output logic            EX_MEMREAD_2,
  output logic [1:0]      EX_RF_WR_SEL,
  output logic [1:0]      dbg_squash_left
);

  // Flow control: DEC_VALID marks a real instruction on the decode inputs;
  // EX_STALL freezes every register and blocks acceptance. An instruction is
  // consumed only on a cycle where DEC_VALID=1 and EX_STALL=0.

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] SQ_INIT   = 2'(SQUASH_SLOTS);

  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} sq_state_t;

  sq_state_t       state;
  logic [1:0]      sq_left;
  logic            live;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            is_jal, is_jalr, is_branch;
  logic            br_eq, br_lt, br_ltu, br_taken;
  logic [2:0]      funct3;

  assign live = DEC_VALID & ~EX_STALL & (state == RUN);

  always_comb begin
    alu_result = '0;
    case (DEC_ALU_FUN)
      4'b0000: alu_result = DEC_ALU_A + DEC_ALU_B;
      4'b1000: alu_result = DEC_ALU_A - DEC_ALU_B;
      4'b0001: alu_result = DEC_ALU_A << DEC_ALU_B[4:0];
      4'b0010: alu_result = {{(XLEN-1){1'b0}}, $signed(DEC_ALU_A) < $signed(DEC_ALU_B)};
      4'b0011: alu_result = {{(XLEN-1){1'b0}}, DEC_ALU_A < DEC_ALU_B};
      4'b0100: alu_result = DEC_ALU_A ^ DEC_ALU_B;
      4'b0101: alu_result = DEC_ALU_A >> DEC_ALU_B[4:0];
      4'b1101: alu_result = $unsigned($signed(DEC_ALU_A) >>> DEC_ALU_B[4:0]);
      4'b0110: alu_result = DEC_ALU_A | DEC_ALU_B;
      4'b0111: alu_result = DEC_ALU_A & DEC_ALU_B;
      4'b1001: alu_result = DEC_ALU_A;
      default: alu_result = '0;
    endcase
  end

  assign funct3    = DEC_MEM_IR[14:12];
  assign is_jal    = (DEC_MEM_IR[6:0] == OP_JAL);
  assign is_jalr   = (DEC_MEM_IR[6:0] == OP_JALR);
  assign is_branch = (DEC_MEM_IR[6:0] == OP_BRANCH);
  assign br_eq     = (DEC_RS1 == DEC_RS2);
  assign br_lt     = ($signed(DEC_RS1) < $signed(DEC_RS2));
  assign br_ltu    = (DEC_RS1 < DEC_RS2);

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = ~br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = ~br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = ~br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  assign jalr_sum = DEC_RS1 + DEC_I_TYPE;

  always_comb begin
    target = '0;
    if (is_jal)         target = DEC_PC + DEC_J_TYPE;
    else if (is_jalr)   target = {jalr_sum[XLEN-1:1], 1'b0};
    else if (is_branch) target = DEC_PC + DEC_B_TYPE;
  end

  assign EX_PC_SEL = live & (is_jal | is_jalr | (is_branch & br_taken));
  assign EX_TARGET = EX_PC_SEL ? target : '0;
  assign dbg_squash_left = (state == SQUASH) ? sq_left : 2'd0;

  // Squash counter only advances on consumed instructions, so bubbles and
  // stalls never eat into the wrong-path budget.
  always_ff @(posedge REG_CLOCK or posedge REG_RESET) begin
    if (REG_RESET) begin
      state   <= RUN;
      sq_left <= '0;
    end else if (!EX_STALL) begin
      case (state)
        RUN: begin
          if (EX_PC_SEL) begin
            state   <= SQUASH;
            sq_left <= SQ_INIT;
          end
        end
        SQUASH: begin
          if (DEC_VALID) begin
            if (sq_left <= 2'd1) begin
              state   <= RUN;
              sq_left <= '0;
            end else begin
              sq_left <= sq_left - 2'd1;
            end
          end
        end
        default: begin
          state   <= RUN;
          sq_left <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge REG_CLOCK or posedge REG_RESET) begin
    if (REG_RESET) begin
      EX_VALID      <= 1'b0;
      EX_ALU_RESULT <= '0;
      EX_RS2_DATA   <= '0;
      EX_MEM_IR     <= '0;
      EX_PC_4       <= '0;
      EX_REGWRITE   <= 1'b0;
      EX_MEMWRITE   <= 1'b0;
      EX_MEMREAD_2  <= 1'b0;
      EX_RF_WR_SEL  <= '0;
    end else if (!EX_STALL) begin
      EX_VALID      <= live;
      EX_ALU_RESULT <= alu_result;
      EX_RS2_DATA   <= DEC_RS2;
      EX_MEM_IR     <= DEC_MEM_IR;
      EX_PC_4       <= DEC_PC_OUT;
      EX_REGWRITE   <= DEC_REGWRITE & live;
      EX_MEMWRITE   <= DEC_MEMWRITE & live;
      EX_MEMREAD_2  <= DEC_MEMREAD_2 & live;
      EX_RF_WR_SEL  <= DEC_RF_WR_SEL;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus randomized traffic checked
// against an instruction-level reference model of the stage.
module tb_execute_stage;

  localparam int SLOTS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_stall, dec_valid;
  logic [31:0] dec_pc, dec_pc_out, dec_alu_a, dec_alu_b, dec_rs1, dec_rs2;
  logic [31:0] dec_j, dec_b, dec_i, dec_ir;
  logic [3:0]  dec_fun;
  logic        dec_regwrite, dec_memwrite, dec_memread;
  logic [1:0]  dec_rf_wr_sel;
  logic        ex_pc_sel, ex_valid, ex_regwrite, ex_memwrite, ex_memread;
  logic [31:0] ex_target, ex_alu, ex_rs2, ex_ir, ex_pc4;
  logic [1:0]  ex_rf_wr_sel, dbg_squash_left;

  int checks = 0;
  int failures = 0;

  // reference model state
  int          m_sq;
  logic        m_live, exp_pc_sel;
  logic [31:0] exp_target;
  logic        e_valid, e_rw, e_mw, e_mr;
  logic [31:0] e_alu, e_rs2, e_ir, e_pc4;
  logic [1:0]  e_sel;

  execute_stage #(.XLEN(32), .SQUASH_SLOTS(SLOTS)) dut (
    .REG_CLOCK(clk), .REG_RESET(rst), .EX_STALL(ex_stall), .DEC_VALID(dec_valid),
    .DEC_PC(dec_pc), .DEC_PC_OUT(dec_pc_out), .DEC_ALU_A(dec_alu_a), .DEC_ALU_B(dec_alu_b),
    .DEC_RS1(dec_rs1), .DEC_RS2(dec_rs2), .DEC_J_TYPE(dec_j), .DEC_B_TYPE(dec_b),
    .DEC_I_TYPE(dec_i), .DEC_MEM_IR(dec_ir), .DEC_ALU_FUN(dec_fun),
    .DEC_REGWRITE(dec_regwrite), .DEC_MEMWRITE(dec_memwrite), .DEC_MEMREAD_2(dec_memread),
    .DEC_RF_WR_SEL(dec_rf_wr_sel), .EX_PC_SEL(ex_pc_sel), .EX_TARGET(ex_target),
    .EX_VALID(ex_valid), .EX_ALU_RESULT(ex_alu), .EX_RS2_DATA(ex_rs2), .EX_MEM_IR(ex_ir),
    .EX_PC_4(ex_pc4), .EX_REGWRITE(ex_regwrite), .EX_MEMWRITE(ex_memwrite),
    .EX_MEMREAD_2(ex_memread), .EX_RF_WR_SEL(ex_rf_wr_sel), .dbg_squash_left(dbg_squash_left)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (f)
      4'd0:  return a + b;
      4'd8:  return a + (~b + 32'd1);
      4'd1:  return a * (32'd1 << sh);
      4'd2:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd3:  return (longint'({32'd0, a}) < longint'({32'd0, b})) ? 32'd1 : 32'd0;
      4'd4:  return a ^ b;
      4'd5:  return a / (32'd1 << sh);
      4'd13: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd9:  return a;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic taken_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_comb();
    logic [6:0]  op;
    logic [31:0] t;
    logic        redirect;
    op = dec_ir[6:0];
    m_live = dec_valid && !ex_stall && (m_sq == 0);
    redirect = 1'b0;
    t = 32'd0;
    if (op == 7'h6F) begin redirect = 1'b1; t = dec_pc + dec_j; end
    else if (op == 7'h67) begin redirect = 1'b1; t = (dec_rs1 + dec_i) & 32'hFFFF_FFFE; end
    else if (op == 7'h63) begin redirect = taken_ref(dec_ir[14:12], dec_rs1, dec_rs2); t = dec_pc + dec_b; end
    exp_pc_sel = m_live && redirect;
    exp_target = exp_pc_sel ? t : 32'd0;
  endtask

  task automatic model_reset();
    m_sq = 0; e_valid = 0; e_rw = 0; e_mw = 0; e_mr = 0;
    e_alu = 0; e_rs2 = 0; e_ir = 0; e_pc4 = 0; e_sel = 0;
  endtask

  // advance one clock, updating the model with the inputs present now
  task automatic tick();
    model_comb();
    if (!ex_stall) begin
      e_valid = m_live;
      e_alu   = alu_ref(dec_fun, dec_alu_a, dec_alu_b);
      e_rs2   = dec_rs2;
      e_ir    = dec_ir;
      e_pc4   = dec_pc_out;
      e_rw    = dec_regwrite & m_live;
      e_mw    = dec_memwrite & m_live;
      e_mr    = dec_memread & m_live;
      e_sel   = dec_rf_wr_sel;
      if (m_sq == 0) begin
        if (exp_pc_sel) m_sq = SLOTS;
      end else if (dec_valid) begin
        m_sq = m_sq - 1;
      end
    end
    @(posedge clk);
    #1;
    model_comb();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    ex_stall = 0; dec_valid = 0; dec_pc = 0; dec_pc_out = 0; dec_alu_a = 0; dec_alu_b = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_j = 0; dec_b = 0; dec_i = 0; dec_ir = 32'h0000_0033;
    dec_fun = 0; dec_regwrite = 0; dec_memwrite = 0; dec_memread = 0; dec_rf_wr_sel = 0;
  endtask

  task automatic drive_rtype(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    drive_idle();
    dec_valid = 1; dec_ir = 32'h0000_0033; dec_fun = f; dec_alu_a = a; dec_alu_b = b;
    dec_regwrite = 1; dec_rf_wr_sel = 2'd3; dec_pc_out = $urandom; dec_rs2 = $urandom;
  endtask

  task automatic drive_branch(input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] pc, input logic [31:0] bimm);
    drive_idle();
    dec_valid = 1; dec_ir = {17'd0, f3, 12'h063}; dec_rs1 = r1; dec_rs2 = r2;
    dec_pc = pc; dec_b = bimm; dec_pc_out = pc + 4; dec_regwrite = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({ex_valid, ex_regwrite, ex_memwrite, ex_memread, ex_pc_sel} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 00000", {ex_valid, ex_regwrite, ex_memwrite, ex_memread, ex_pc_sel});
    end
    checks++;
    if ({ex_alu, ex_rs2, ex_ir, ex_pc4} !== 128'd0) begin
      failures++; $display("FAIL reset_data: got %h expected 0", {ex_alu, ex_rs2, ex_ir, ex_pc4});
    end
    checks++;
    if (dbg_squash_left !== 2'd0) begin
      failures++; $display("FAIL reset_fsm: got %0d expected 0", dbg_squash_left);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    logic [3:0]  f[7]   = '{4'b0000, 4'b1101, 4'b0011, 4'b1000, 4'b0010, 4'b1001, 4'b1010};
    logic [31:0] a[7]   = '{32'd7, 32'h8000_0000, 32'd1, 32'd5, 32'hFFFF_FFFF, 32'h1234_5000, 32'hDEAD_BEEF};
    logic [31:0] b[7]   = '{32'hFFFF_FFFE, 32'd4, 32'hFFFF_FFFF, 32'd7, 32'd1, 32'h0000_0FFF, 32'h0000_0001};
    logic [31:0] exp[7] = '{32'd5, 32'hF800_0000, 32'd1, 32'hFFFF_FFFE, 32'd1, 32'h1234_5000, 32'd0};
    for (int k = 0; k < 7; k++) begin
      drive_rtype(f[k], a[k], b[k]);
      tick();
      checks++;
      if (ex_alu !== exp[k]) begin
        failures++; $display("FAIL alu_%0d: got %h expected %h", k, ex_alu, exp[k]);
      end
      checks++;
      if ({ex_valid, ex_regwrite} !== 2'b11) begin
        failures++; $display("FAIL alu_valid_%0d: got %b expected 11", k, {ex_valid, ex_regwrite});
      end
    end
  endtask

  task automatic test_branch_squash();
    drive_branch(3'b000, 32'd9, 32'd9, 32'h100, 32'h20);
    #1;
    checks++;
    if ({ex_pc_sel, ex_target} !== {1'b1, 32'h120}) begin
      failures++; $display("FAIL beq_redirect: got %b/%h expected 1/00000120", ex_pc_sel, ex_target);
    end
    tick();
    checks++;
    if (dbg_squash_left !== 2'd2) begin
      failures++; $display("FAIL beq_fsm: got %0d expected 2", dbg_squash_left);
    end
    for (int k = 0; k < 2; k++) begin
      drive_branch(3'b000, 32'd9, 32'd9, 32'h300, 32'h40);
      #1;
      checks++;
      if (ex_pc_sel !== 1'b0) begin
        failures++; $display("FAIL squash_noredirect_%0d: got %b expected 0", k, ex_pc_sel);
      end
      tick();
      checks++;
      if ({ex_valid, ex_regwrite} !== 2'b00) begin
        failures++; $display("FAIL squash_slot_%0d: got %b expected 00", k, {ex_valid, ex_regwrite});
      end
      if (k == 0) begin
        drive_idle();
        tick();
        checks++;
        if (dbg_squash_left !== 2'd1) begin
          failures++; $display("FAIL squash_bubble_hold: got %0d expected 1", dbg_squash_left);
        end
      end
    end
    drive_rtype(4'b0000, 32'd1, 32'd2);
    tick();
    checks++;
    if ({ex_valid, ex_regwrite, ex_alu} !== {2'b11, 32'd3}) begin
      failures++; $display("FAIL squash_third: got %b/%h expected 11/00000003", {ex_valid, ex_regwrite}, ex_alu);
    end
  endtask

  task automatic test_jalr();
    drive_idle();
    dec_valid = 1; dec_ir = 32'h0000_00E7; dec_rs1 = 32'h2003; dec_i = 32'd4;
    dec_pc = 32'h0000_ABC0; dec_pc_out = 32'h0000_ABC4; dec_regwrite = 1;
    #1;
    checks++;
    if ({ex_pc_sel, ex_target} !== {1'b1, 32'h2006}) begin
      failures++; $display("FAIL jalr_redirect: got %b/%h expected 1/00002006", ex_pc_sel, ex_target);
    end
    tick();
    checks++;
    if ({ex_valid, ex_pc4} !== {1'b1, 32'h0000_ABC4}) begin
      failures++; $display("FAIL jalr_pc4: got %b/%h expected 1/0000abc4", ex_valid, ex_pc4);
    end
    drive_rtype(4'b0100, 32'hF0F0, 32'h0FF0);
    tick();
    tick();
  endtask

  task automatic test_stall_redirect();
    logic [31:0] hold_alu;
    logic        hold_valid;
    drive_rtype(4'b0110, 32'h00F0, 32'h0F00);
    tick();
    hold_alu = e_alu;
    hold_valid = e_valid;
    drive_branch(3'b001, 32'd1, 32'd2, 32'h200, 32'h40);
    ex_stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ex_pc_sel !== 1'b0) begin
        failures++; $display("FAIL stall_pcsel_%0d: got %b expected 0", k, ex_pc_sel);
      end
      tick();
      checks++;
      if ({ex_valid, ex_alu} !== {hold_valid, hold_alu}) begin
        failures++; $display("FAIL stall_hold_%0d: got %b/%h expected %b/%h", k, ex_valid, ex_alu, hold_valid, hold_alu);
      end
    end
    ex_stall = 0;
    #1;
    checks++;
    if ({ex_pc_sel, ex_target} !== {1'b1, 32'h240}) begin
      failures++; $display("FAIL stall_release_redirect: got %b/%h expected 1/00000240", ex_pc_sel, ex_target);
    end
    tick();
    checks++;
    if ({ex_valid, dbg_squash_left} !== {1'b1, 2'd2}) begin
      failures++; $display("FAIL stall_release_fsm: got %b/%0d expected 1/2", ex_valid, dbg_squash_left);
    end
    drive_rtype(4'b0000, 32'd0, 32'd0);
    tick();
    tick();
  endtask

  task automatic test_reset_mid_squash();
    drive_branch(3'b000, 32'd4, 32'd4, 32'h400, 32'h10);
    tick();
    drive_rtype(4'b0000, 32'd3, 32'd3);
    tick();
    checks++;
    if (dbg_squash_left !== 2'd1) begin
      failures++; $display("FAIL midsq_setup: got %0d expected 1", dbg_squash_left);
    end
    drive_idle();
    #2 rst = 1;
    model_reset();
    #1;
    checks++;
    if ({ex_valid, ex_regwrite, ex_pc4, ex_ir, dbg_squash_left} !== 68'd0) begin
      failures++; $display("FAIL midsq_async_reset: got %b/%b/%h/%h/%0d expected all 0",
                           ex_valid, ex_regwrite, ex_pc4, ex_ir, dbg_squash_left);
    end
    #1 rst = 0;
    drive_rtype(4'b0111, 32'hFF00, 32'h0FF0);
    tick();
    checks++;
    if ({ex_valid, ex_regwrite, ex_alu} !== {2'b11, 32'h0F00}) begin
      failures++; $display("FAIL midsq_after_reset: got %b/%h expected 11/00000f00", {ex_valid, ex_regwrite}, ex_alu);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[5] = '{7'h6F, 7'h67, 7'h63, 7'h33, 7'h03};
    for (int n = 0; n < 400; n++) begin
      ex_stall = ($urandom_range(0, 4) == 0);
      dec_valid = ($urandom_range(0, 3) != 0);
      dec_pc = $urandom; dec_pc_out = dec_pc + 4;
      dec_alu_a = $urandom; dec_alu_b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      dec_rs1 = $urandom; dec_rs2 = ($urandom_range(0, 2) == 0) ? dec_rs1 : $urandom;
      dec_j = $urandom; dec_b = $urandom; dec_i = $urandom;
      dec_ir = $urandom;
      dec_ir[6:0] = ops[$urandom_range(0, 4)];
      dec_fun = 4'($urandom_range(0, 15));
      dec_regwrite = 1'($urandom); dec_memwrite = 1'($urandom); dec_memread = 1'($urandom);
      dec_rf_wr_sel = 2'($urandom);
      model_comb();
      #1;
      checks++;
      if ({ex_pc_sel, ex_target} !== {exp_pc_sel, exp_target}) begin
        failures++; $display("FAIL rand_redirect_%0d: got %b/%h expected %b/%h", n, ex_pc_sel, ex_target, exp_pc_sel, exp_target);
      end
      tick();
      checks++;
      if ({ex_valid, ex_regwrite, ex_memwrite, ex_memread, ex_rf_wr_sel} !== {e_valid, e_rw, e_mw, e_mr, e_sel}) begin
        failures++; $display("FAIL rand_ctrl_%0d: got %b expected %b", n,
                             {ex_valid, ex_regwrite, ex_memwrite, ex_memread, ex_rf_wr_sel}, {e_valid, e_rw, e_mw, e_mr, e_sel});
      end
      checks++;
      if ({ex_alu, ex_rs2, ex_ir, ex_pc4} !== {e_alu, e_rs2, e_ir, e_pc4}) begin
        failures++; $display("FAIL rand_data_%0d: got %h/%h/%h/%h expected %h/%h/%h/%h", n,
                             ex_alu, ex_rs2, ex_ir, ex_pc4, e_alu, e_rs2, e_ir, e_pc4);
      end
      checks++;
      if (dbg_squash_left !== 2'(m_sq)) begin
        failures++; $display("FAIL rand_fsm_%0d: got %0d expected %0d", n, dbg_squash_left, m_sq);
      end
    end
  endtask

  initial begin
    rst = 1;
    drive_idle();
    model_reset();
    test_reset();
    test_alu();
    test_branch_squash();
    test_jalr();
    test_stall_redirect();
    test_reset_mid_squash();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
